universal_shifter: RTL and testbench

Parametrised universal shift register: generalises the switch/key-driven 8-bit load/shift-right/arithmetic-shift register to WIDTH bits, with six shift/load modes, a multi-step shift amount and a start/busy/done handshake. It executes one operation per request and advances one bit position per clock. It sits between board I/O or control FSMs and datapath blocks that need a serially-adjusted register value.

---
 rtl/universal_shifter_if.sv | 26 ++
 rtl/universal_shifter.sv | 130 +++++++++++++
 tb/tb_universal_shifter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/universal_shifter_if.sv
// Request/response bundle for universal_shifter: op request fields in, register state and handshake out.
// Plain wires; timing and flow control belong to the shifter itself.
interface universal_shifter_if #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 3
);
   logic               start;
   logic [2:0]         op;
   logic [WIDTH-1:0]   load_val;
   logic [SHAMT_W-1:0] amount;
   logic               serial_in;
   logic [WIDTH-1:0]   q;
   logic               serial_out;
   logic               busy;
   logic               done;

   modport master (
      output start, op, load_val, amount, serial_in,
      input  q, serial_out, busy, done
   );

   modport slave (
      input  start, op, load_val, amount, serial_in,
      output q, serial_out, busy, done
   );
endinterface

// File: rtl/universal_shifter.sv
// Universal shift register: load/clear/nop in one edge, shifts/rotates one bit per edge for 'amount' steps.
// Latency 1 edge (single-cycle ops) or amount+1 edges; start is ignored while busy, nothing is queued.
module universal_shifter #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   universal_shifter_if.slave bus
);
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_LSR   = 3'b001;
   localparam logic [2:0] OP_ASR   = 3'b010;
   localparam logic [2:0] OP_LSL   = 3'b011;
   localparam logic [2:0] OP_ROR   = 3'b100;
   localparam logic [2:0] OP_ROL   = 3'b101;
   localparam logic [2:0] OP_CLEAR = 3'b110;

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t             state, state_nxt;
   logic [2:0]         op_r, op_nxt;
   logic [SHAMT_W-1:0] remaining, remaining_nxt;
   logic [WIDTH-1:0]   q, q_nxt, step_q;
   logic               serial_out, serial_out_nxt, step_bit;
   logic               busy, busy_nxt;
   logic               done, done_nxt;
   logic               is_shift;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         op_r       <= OP_LOAD;
         remaining  <= '0;
         q          <= '0;
         serial_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         op_r       <= op_nxt;
         remaining  <= remaining_nxt;
         q          <= q_nxt;
         serial_out <= serial_out_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   // One single-bit step of the latched operation; serial_in is taken live at each step edge.
   always_comb begin
      step_q   = q;
      step_bit = serial_out;
      case (op_r)
         OP_LSR: begin
            step_q   = {bus.serial_in, q[WIDTH-1:1]};
            step_bit = q[0];
         end
         OP_ASR: begin
            step_q   = {q[WIDTH-1], q[WIDTH-1:1]};
            step_bit = q[0];
         end
         OP_LSL: begin
            step_q   = {q[WIDTH-2:0], bus.serial_in};
            step_bit = q[WIDTH-1];
         end
         OP_ROR: begin
            step_q   = {q[0], q[WIDTH-1:1]};
            step_bit = q[0];
         end
         OP_ROL: begin
            step_q   = {q[WIDTH-2:0], q[WIDTH-1]};
            step_bit = q[WIDTH-1];
         end
         default: begin
            step_q   = q;
            step_bit = serial_out;
         end
      endcase
   end

   assign is_shift = (bus.op == OP_LSR) || (bus.op == OP_ASR) || (bus.op == OP_LSL) ||
                     (bus.op == OP_ROR) || (bus.op == OP_ROL);

   always_comb begin
      state_nxt      = state;
      op_nxt         = op_r;
      remaining_nxt  = remaining;
      q_nxt          = q;
      serial_out_nxt = serial_out;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (is_shift && (bus.amount != '0)) begin
                  op_nxt        = bus.op;
                  remaining_nxt = bus.amount;
                  busy_nxt      = 1'b1;
                  state_nxt     = SHIFT;
               end else begin
                  // Zero-amount shifts complete like NOP: done pulse only.
                  done_nxt = 1'b1;
                  if (bus.op == OP_LOAD) begin
                     q_nxt = bus.load_val;
                  end else if (bus.op == OP_CLEAR) begin
                     q_nxt = '0;
                  end
               end
            end
         end
         SHIFT: begin
            q_nxt          = step_q;
            serial_out_nxt = step_bit;
            remaining_nxt  = remaining - SHAMT_W'(1);
            if (remaining == SHAMT_W'(1)) begin
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.q          = q;
   assign bus.serial_out = serial_out;
   assign bus.busy       = busy;
   assign bus.done       = done;
endmodule

// File: tb/tb_universal_shifter.sv
// Scoreboard bench for universal_shifter (WIDTH=8, SHAMT_W=3): directed scenarios plus random ops
// against a word-level arithmetic reference model.
module tb_universal_shifter;
   localparam logic [2:0] LOAD = 3'd0, LSR = 3'd1, ASR = 3'd2, LSL = 3'd3;
   localparam logic [2:0] ROR  = 3'd4, ROL = 3'd5, CLR = 3'd6, NOP = 3'd7;

   typedef struct {
      logic [7:0] q;
      logic       so;
      int         cyc;
      int         busy_n;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   universal_shifter_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

   universal_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t       sb[$];
   exp_t       e;
   int         passed   = 0;
   int         total    = 0;
   int         cyc      = 0;
   int         busy_cnt = 0;
   logic [7:0] mq       = 8'h00;
   logic       mso      = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference: whole-word arithmetic for an n-step operation (n <= 7 here).
   task automatic model_op(input logic [2:0] o, input logic [7:0] v, input int n,
                           input logic s, output int n_eff);
      int r;
      n_eff = 0;
      r     = n % 8;
      case (o)
         LOAD: mq = v;
         CLR:  mq = 8'h00;
         NOP:  ;
         default: if (n != 0) begin
            n_eff = n;
            case (o)
               LSR: begin mso = mq[n-1];     mq = (mq >> n) | (s ? (8'hFF << (8 - n)) : 8'h00); end
               ASR: begin mso = mq[n-1];     mq = $signed(mq) >>> n; end
               LSL: begin mso = mq[8-n];     mq = (mq << n) | (s ? (8'hFF >> (8 - n)) : 8'h00); end
               ROR: begin mso = mq[(n-1)%8]; mq = (mq >> r) | (mq << (8 - r)); end
               default: begin mso = mq[7-((n-1)%8)]; mq = (mq << r) | (mq >> (8 - r)); end
            endcase
         end
      endcase
   endtask

   // Called at a negedge with busy low; returns at the negedge after the start edge.
   task automatic start_op(input logic [2:0] o, input logic [7:0] v, input int n, input logic s);
      int ne;
      model_op(o, v, n, s, ne);
      sb.push_back('{q: mq, so: mso, cyc: cyc + 1 + ne, busy_n: ne});
      bus.start     = 1'b1;
      bus.op        = o;
      bus.load_val  = v;
      bus.amount    = 3'(n);
      bus.serial_in = s;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (bus.busy && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (bus.busy) begin
         total++;
         $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", t);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [7:0] v, input int n, input logic s);
      start_op(o, v, n, s);
      wait_idle();
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         busy_cnt = 0;
      end else begin
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("q_at_done", bus.q, e.q);
               check("serial_out_at_done", bus.serial_out, e.so);
               check("done_cycle", cyc, e.cyc);
               check("busy_cycles", busy_cnt, e.busy_n);
            end
            busy_cnt = 0;
         end
         if (bus.busy) busy_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.start     = 1'b0;
      bus.op        = NOP;
      bus.load_val  = 8'h00;
      bus.amount    = 3'd0;
      bus.serial_in = 1'b0;
      #1;
      check("reset_q", bus.q, 8'h00);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
      check("reset_serial_out", bus.serial_out, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // ASR with step-by-step trace
      issue(LOAD, 8'hB5, 0, 1'b0);
      start_op(ASR, 8'h00, 3, 1'b0);
      check("asr_q_e0", bus.q, 8'hB5);
      check("asr_busy_e0", bus.busy, 1'b1);
      @(negedge clk); check("asr_q_e1", bus.q, 8'hDA);
      @(negedge clk); check("asr_q_e2", bus.q, 8'hED);
      @(negedge clk); check("asr_q_e3", bus.q, 8'hF6);
      wait_idle();

      issue(LOAD, 8'h81, 0, 1'b0);
      issue(ROL,  8'h00, 1, 1'b0);
      issue(LOAD, 8'h81, 0, 1'b0);
      issue(ROR,  8'h00, 7, 1'b0);
      issue(LOAD, 8'h0F, 0, 1'b0);
      issue(LSL,  8'h00, 4, 1'b1);
      issue(LSR,  8'h00, 7, 1'b0);

      // Start pulsed mid-shift must be ignored
      issue(LOAD, 8'hF0, 0, 1'b0);
      start_op(LSR, 8'h00, 4, 1'b0);
      bus.start    = 1'b1;
      bus.op       = LOAD;
      bus.load_val = 8'h55;
      bus.amount   = 3'd1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      check("ignored_start_q", bus.q, 8'h0F);

      issue(LOAD, 8'h3C, 0, 1'b0);
      issue(LSR,  8'h00, 0, 1'b1);
      issue(ROL,  8'h00, 2, 1'b0);
      issue(NOP,  8'hAA, 5, 1'b1);
      issue(CLR,  8'hAA, 3, 1'b0);

      // Reset mid-shift takes effect without a clock edge
      issue(LOAD, 8'hFF, 0, 1'b0);
      start_op(LSR, 8'h00, 5, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_q", bus.q, 8'h00);
      check("midreset_busy", bus.busy, 1'b0);
      check("midreset_done", bus.done, 1'b0);
      check("midreset_serial_out", bus.serial_out, 1'b0);
      sb.delete();
      mq  = 8'h00;
      mso = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 200; i++) begin
         issue(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
